xor_frame_parity: RTL and testbench
===================================

# xor_frame_parity

Parametrised, registered successor to the two-input XOR gate. It accumulates a running bitwise XOR across a frame of `WIDTH`-bit words delivered on a valid/ready stream. At frame end it presents the word-parity, the single-bit reduction parity, the beat count and an overflow flag on a held output handshake. It sits between a streaming data source and an integrity-check consumer, such as a packet checker or a self-test comparator.

## Interface

Parameters:
- `WIDTH`, 8: data word width in bits, ≥1.
- `MAX_LEN`, 16: maximum legal beats per frame, ≥1.
- `CW`, derived, `$clog2(MAX_LEN+1)`: count width. Not overridable.

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_data` in WIDTH: input word.
- `in_last` in 1: the beat is the final beat of its frame.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_parity` out WIDTH: XOR of all words in the frame.
- `out_bit` out 1: XOR-reduction of `out_parity`.
- `out_count` out CW: beats in the frame, saturating at `MAX_LEN`.
- `out_overflow` out 1: the frame exceeded `MAX_LEN` beats.

## Operation

- States:
  - ACC: accepting beats.
  - DONE: holding a result.
- Port behaviour by state:
  - `in_ready` = 1 only in ACC.
  - `out_valid` = 1 only in DONE.
- Internal registers: `acc` (WIDTH), `cnt` (CW), `ovf` (1).
- Beat transfer = `in_valid & in_ready`. On each transfer:
  - `acc <= acc ^ in_data`.
  - `cnt <= (cnt == MAX_LEN) ? cnt : cnt+1`.
  - If `cnt == MAX_LEN` when the beat arrives, `ovf <= 1` (sticky for the frame).
- Transfer with `in_last = 1`:
  - Result registers load the post-update values of `acc`, `cnt` and `ovf`.
  - State goes to DONE.
  - `acc`, `cnt` and `ovf` clear to 0.
- Non-last transfer: stay in ACC.
- DONE:
  - Outputs are held stable until `out_valid & out_ready`.
  - On that handshake, return to ACC.
  - `in_data` is ignored while in DONE.
- `out_bit` is always `^out_parity`, registered alongside it, never computed combinationally from inputs.
- `in_valid` without a transfer (DONE state) has no effect. The beat must be held by the source.
- A zero-beat frame is impossible: every frame contains at least the `in_last` beat.

## Timing

- Reset (`rst` high at a clock edge) produces:
  - state = ACC.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_parity` = 0, `out_bit` = 0, `out_count` = 0, `out_overflow` = 0.
  - `acc`, `cnt` and `ovf` = 0.
- Reset mid-frame or in DONE discards all partial or held results. It takes priority over any same-cycle handshake.
- Latency: `out_valid` rises the cycle after the `in_last` transfer edge.
- `out_valid` falls the cycle after the `out_valid & out_ready` edge. `in_ready` rises in that same cycle.
- Throughput:
  - Minimum one DONE cycle between frames.
  - An N-beat frame with `out_ready` held high occupies N+1 cycles.
- Back-to-back beats are accepted every cycle in ACC with no bubbles.
- `out_ready` asserted before `out_valid` is allowed. The handshake completes on the first DONE cycle.
- Count saturation:
  - `out_count` never exceeds `MAX_LEN`.
  - Beat `MAX_LEN+1` sets `out_overflow`. `out_parity` still includes every beat.

## Test plan

All scenarios use `WIDTH` = 8 and `MAX_LEN` = 16.

1. Reset then idle:
   - Stimulus: assert `rst` 2 cycles, hold `in_valid` = 0.
   - Required: `in_ready` = 1, `out_valid` = 0, all outputs 0.
2. Four-beat frame, `out_ready` = 1:
   - Stimulus: words 0x0F, 0xF0, 0xAA, 0x55 (last on 0x55).
   - Required: one cycle later `out_parity` = 0x00, `out_bit` = 0, `out_count` = 4, `out_overflow` = 0. `out_valid` is high exactly one cycle.
3. Backpressure:
   - Stimulus: frame 0x01, 0x02, 0x04 with `out_ready` = 0 for 5 cycles. A second frame is presented meanwhile.
   - Required: `out_parity` = 0x07, `out_bit` = 1, `out_count` = 3, all held stable. `in_ready` = 0 throughout. The second frame is accepted only after the handshake.
4. Single-beat frame:
   - Stimulus: 0x80 with `in_last`.
   - Required: `out_parity` = 0x80, `out_bit` = 1, `out_count` = 1.
5. Overflow:
   - Stimulus: 17 beats of 0x01, last on the 17th.
   - Required: `out_parity` = 0x01, `out_count` = 16, `out_overflow` = 1. The next frame reports `out_overflow` = 0.
6. Reset mid-frame:
   - Stimulus: 2 beats of 0xFF, pulse `rst`, then frame 0x3C (last).
   - Required: `out_parity` = 0x3C, `out_count` = 1. No result from the aborted frame.

Source files
------------

// File: rtl/xor_frame_parity.sv
// xor_frame_parity
// Accumulates a running bitwise XOR over a frame of WIDTH-bit words that
// arrive on a valid/ready stream. When the last beat of a frame is accepted,
// the block latches the frame parity, its single-bit reduction, the saturating
// beat count and an overflow flag. It holds them on the output handshake until
// the consumer takes them.
//
// Handshake semantics (both ports):
//   A beat or result moves on a rising clock edge where valid and ready are
//   both high. A source that raises valid keeps valid and its payload stable
//   until that edge. Ready may be high before valid arrives. in_ready is high
//   only while accumulating. out_valid is high only while a result is held.
//   The two ports are never open at the same time, so consecutive frames are
//   always separated by at least one result cycle.
module xor_frame_parity #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_parity,
    output logic             out_bit,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow,
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_parity_q, res_parity_d;
    logic             res_bit_q, res_bit_d;
    logic [CW-1:0]    res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] acc_upd;
    logic [CW-1:0]    cnt_upd;
    logic             ovf_upd;

    assign in_ready     = (state_q == ST_ACC);
    assign out_valid    = (state_q == ST_DONE);
    assign in_xfer      = in_valid & in_ready;
    assign out_xfer     = out_valid & out_ready;

    assign out_parity   = res_parity_q;
    assign out_bit      = res_bit_q;
    assign out_count    = res_count_q;
    assign out_overflow = res_ovf_q;
    assign dbg_state_o  = state_q;

    // Accumulator values after the beat on in_data is folded in. The count
    // saturates at MAX_LEN; a beat that arrives at saturation marks overflow.
    always_comb begin
        acc_upd = acc_q ^ in_data;
        cnt_upd = cnt_q;
        ovf_upd = ovf_q;
        if (cnt_q == CNT_MAX) begin
            ovf_upd = 1'b1;
        end else begin
            cnt_upd = cnt_q + CW'(1);
        end
    end

    // Next state: fold accepted beats, latch the result on the last beat,
    // release it on the output handshake.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        res_parity_d = res_parity_q;
        res_bit_d    = res_bit_q;
        res_count_d  = res_count_q;
        res_ovf_d    = res_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (in_xfer) begin
                    if (in_last) begin
                        res_parity_d = acc_upd;
                        res_bit_d    = ^acc_upd;
                        res_count_d  = cnt_upd;
                        res_ovf_d    = ovf_upd;
                        acc_d        = '0;
                        cnt_d        = '0;
                        ovf_d        = 1'b0;
                        state_d      = ST_DONE;
                    end else begin
                        acc_d = acc_upd;
                        cnt_d = cnt_upd;
                        ovf_d = ovf_upd;
                    end
                end
            end
            ST_DONE: begin
                if (out_xfer) begin
                    state_d = ST_ACC;
                end
            end
        endcase
    end

    // State and data registers. Reset wins over any same-cycle handshake and
    // discards both a partial frame and a held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            res_parity_q <= '0;
            res_bit_q    <= 1'b0;
            res_count_q  <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            res_parity_q <= res_parity_d;
            res_bit_q    <= res_bit_d;
            res_count_q  <= res_count_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Bench for xor_frame_parity with WIDTH=8, MAX_LEN=16. Inputs change and
// outputs are sampled on the falling edge; the DUT works on the rising edge.
module tb_xor_frame_parity;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_parity;
    logic       out_bit;
    logic [4:0] out_count;
    logic       out_overflow;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];

    xor_frame_parity #(.WIDTH(8), .MAX_LEN(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_parity   (out_parity),
        .out_bit      (out_bit),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: parity is the XOR of every word, the count is the frame
    // length clipped to 16, overflow means more than 16 words.
    function automatic void model(output logic [7:0] p, output logic b,
                                  output logic [4:0] c, output logic o);
        int n;
        n = frame_q.size();
        p = 8'h00;
        foreach (frame_q[i]) p = p ^ frame_q[i];
        b = ($countones(p) % 2) == 1;
        c = 5'((n > 16) ? 16 : n);
        o = (n > 16);
    endfunction

    // Sends frame_q starting at a falling edge; returns at the falling edge
    // after the last beat was taken. stalls counts cycles spent waiting.
    task automatic send_frame(input bit gaps, output bit ok, output int stalls);
        int waited;
        ok = 1'b1;
        stalls = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            waited = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            stalls += waited;
            if (!in_ready) begin
                ok = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output bit seen);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_parity !== 8'h00) begin errors++; $display("FAIL reset_parity got %h want 00", out_parity); end
        checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL reset_bit got %b want 0", out_bit); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", out_overflow); end
    endtask

    task automatic test_four_beat();
        bit ok; int stalls;
        out_ready = 1'b1;
        frame_q = '{8'h0F, 8'hF0, 8'hAA, 8'h55};
        send_frame(1'b0, ok, stalls);
        checks++; if (!ok) begin errors++; $display("FAIL four_accept timeout"); end
        checks++; if (stalls != 0) begin errors++; $display("FAIL four_bubbles got %0d want 0", stalls); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL four_latency out_valid got %b want 1", out_valid); end
        checks++; if (out_parity !== 8'h00) begin errors++; $display("FAIL four_parity got %h want 00", out_parity); end
        checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL four_bit got %b want 0", out_bit); end
        checks++; if (out_count !== 5'd4) begin errors++; $display("FAIL four_count got %0d want 4", out_count); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL four_overflow got %b want 0", out_overflow); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL four_valid_one_cycle got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL four_ready_back got %b want 1", in_ready); end
    endtask

    task automatic test_backpressure();
        bit ok; int stalls;
        out_ready = 1'b0;
        frame_q = '{8'h01, 8'h02, 8'h04};
        send_frame(1'b0, ok, stalls);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept timeout"); end
        in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, out_valid); end
            checks++; if (out_parity !== 8'h07) begin errors++; $display("FAIL bp_hold_parity cyc %0d got %h want 07", i, out_parity); end
            checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL bp_hold_bit cyc %0d got %b want 1", i, out_bit); end
            checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL bp_hold_count cyc %0d got %0d want 3", i, out_count); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b want 1", out_valid); end
        checks++; if (out_parity !== 8'h99) begin errors++; $display("FAIL bp_second_parity got %h want 99", out_parity); end
        checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL bp_second_count got %0d want 1", out_count); end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok; int stalls;
        out_ready = 1'b1;
        frame_q = '{8'h80};
        send_frame(1'b0, ok, stalls);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept timeout"); end
        checks++; if (out_parity !== 8'h80) begin errors++; $display("FAIL single_parity got %h want 80", out_parity); end
        checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL single_bit got %b want 1", out_bit); end
        checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", out_count); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        bit ok; int stalls;
        out_ready = 1'b1;
        frame_q = {};
        for (int i = 0; i < 16; i++) frame_q.push_back(8'h01);
        send_frame(1'b0, ok, stalls);
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL max_len_count got %0d want 16", out_count); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL max_len_overflow got %b want 0", out_overflow); end
        checks++; if (out_parity !== 8'h00) begin errors++; $display("FAIL max_len_parity got %h want 00", out_parity); end
        @(negedge clk);
        frame_q.push_back(8'h01);
        send_frame(1'b0, ok, stalls);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_accept timeout"); end
        checks++; if (out_parity !== 8'h01) begin errors++; $display("FAIL ovf_parity got %h want 01", out_parity); end
        checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL ovf_bit got %b want 1", out_bit); end
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", out_count); end
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", out_overflow); end
        @(negedge clk);
        frame_q = '{8'h01, 8'h02};
        send_frame(1'b0, ok, stalls);
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_next_clear got %b want 0", out_overflow); end
        checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL ovf_next_count got %0d want 2", out_count); end
        checks++; if (out_parity !== 8'h03) begin errors++; $display("FAIL ovf_next_parity got %h want 03", out_parity); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; int stalls;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_result got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
        frame_q = '{8'h3C};
        send_frame(1'b0, ok, stalls);
        checks++; if (!ok) begin errors++; $display("FAIL mid_accept timeout"); end
        checks++; if (out_parity !== 8'h3C) begin errors++; $display("FAIL mid_parity got %h want 3c", out_parity); end
        checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL mid_count got %0d want 1", out_count); end
        @(negedge clk);
        // reset while a result is held, with a same-cycle handshake
        out_ready = 1'b0;
        frame_q = '{8'h11};
        send_frame(1'b0, ok, stalls);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_reset_valid got %b want 0", out_valid); end
        checks++; if (out_parity !== 8'h00) begin errors++; $display("FAIL done_reset_parity got %h want 00", out_parity); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL done_reset_count got %0d want 0", out_count); end
    endtask

    task automatic test_random();
        bit ok, seen; int stalls, len, hold;
        logic [7:0] ep; logic eb; logic [4:0] ec; logic eo;
        for (int f = 0; f < 40; f++) begin
            out_ready = 1'b0;
            len = $urandom_range(1, 20);
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            model(ep, eb, ec, eo);
            send_frame(1'b1, ok, stalls);
            wait_valid(seen);
            checks++; if (!(ok && seen)) begin errors++; $display("FAIL rnd_frame %0d no result", f); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                checks++; if (out_parity !== ep) begin errors++; $display("FAIL rnd_parity frame %0d got %h want %h", f, out_parity, ep); end
                checks++; if (out_bit !== eb) begin errors++; $display("FAIL rnd_bit frame %0d got %b want %b", f, out_bit, eb); end
                checks++; if (out_count !== ec) begin errors++; $display("FAIL rnd_count frame %0d got %0d want %0d", f, out_count, ec); end
                checks++; if (out_overflow !== eo) begin errors++; $display("FAIL rnd_overflow frame %0d got %b want %b", f, out_overflow, eo); end
                if (h < hold) @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_release frame %0d got %b want 0", f, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_four_beat();
        test_backpressure();
        test_single();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
